// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, signed or unsigned
// operands, start/busy/done handshake with synchronous abort.
module booth_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state;
   logic [WIDTH+1:0]     r_a;
   logic [WIDTH+1:0]     r_m;
   logic [WIDTH:0]       r_q;
   logic                 r_q1;
   logic [CW-1:0]        r_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_ms;
   logic                 w_qs;
   logic [WIDTH+1:0]     w_m_ext;
   logic [WIDTH:0]       w_q_ext;
   logic [WIDTH+1:0]     w_sum;
   logic [WIDTH+1:0]     w_a_nxt;
   logic [WIDTH:0]       w_q_nxt;
   logic                 w_accept;

   // One extra bit of extension makes unsigned operands look like positive signed ones,
   // so the same Booth recoding covers both modes.
   assign w_ms    = signed_mode & multiplicand[WIDTH-1];
   assign w_qs    = signed_mode & multiplier[WIDTH-1];
   assign w_m_ext = {w_ms, w_ms, multiplicand};
   assign w_q_ext = {w_qs, multiplier};

   always_comb begin
      w_sum = r_a;
      case ({r_q[0], r_q1})
         2'b10:   w_sum = r_a - r_m;
         2'b01:   w_sum = r_a + r_m;
         default: w_sum = r_a;
      endcase
   end

   assign w_a_nxt  = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
   assign w_q_nxt  = {w_sum[0], r_q[WIDTH:1]};
   assign w_accept = start & ~abort;

   // DONE accepts a new start like IDLE does, giving one operation per WIDTH+2 cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_m       <= '0;
         r_q       <= '0;
         r_q1      <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_a     <= '0;
                  r_m     <= w_m_ext;
                  r_q     <= w_q_ext;
                  r_q1    <= 1'b0;
                  r_cnt   <= CW'(WIDTH + 1);
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_a   <= w_a_nxt;
                  r_q   <= w_q_nxt;
                  r_q1  <= r_q[0];
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) begin
                     r_product <= {w_a_nxt[WIDTH-2:0], w_q_nxt};
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: WIDTH=8 directed+random with protocol model,
// WIDTH=4 exhaustive and WIDTH=16 random against a plain-arithmetic reference.
module tb_booth_seq_mult;
   localparam int W   = 8;
   localparam int W4  = 4;
   localparam int W16 = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rst2_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // WIDTH=8 DUT
   logic         start, abort, sm;
   logic [7:0]   mc, mp;
   logic         busy, done;
   logic [15:0]  prod;

   booth_seq_mult #(.WIDTH(W)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .signed_mode(sm),
      .multiplicand(mc), .multiplier(mp), .busy(busy), .done(done), .product(prod));

   // WIDTH=4 DUT
   logic         s4, ab4, sm4;
   logic [3:0]   m4, q4v;
   logic         busy4, done4;
   logic [7:0]   prod4;

   booth_seq_mult #(.WIDTH(W4)) dut4 (
      .clk(clk), .rst_n(rst2_n), .start(s4), .abort(ab4), .signed_mode(sm4),
      .multiplicand(m4), .multiplier(q4v), .busy(busy4), .done(done4), .product(prod4));

   // WIDTH=16 DUT
   logic         s16, ab16, sm16;
   logic [15:0]  m16, q16v;
   logic         busy16, done16;
   logic [31:0]  prod16;

   booth_seq_mult #(.WIDTH(W16)) dut16 (
      .clk(clk), .rst_n(rst2_n), .start(s16), .abort(ab16), .signed_mode(sm16),
      .multiplicand(m16), .multiplier(q16v), .busy(busy16), .done(done16), .product(prod16));

   typedef struct {
      logic [31:0] p;
      int          c;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp4[$];
   logic [31:0] exp16[$];
   exp_t        mx;

   // protocol model for the WIDTH=8 DUT: edge numbers of accept, last busy cycle, next free edge
   int acc = 1 << 30, bu = -1, pacc = 1 << 30, pbu = -1;
   int free_at = 0, run_lo = 0, run_hi = -1;
   logic [31:0] last_prod = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input int w, input bit s,
                                            input logic [15:0] m, input logic [15:0] q);
      longint one, a, b, mask;
      one  = 1;
      mask = (one << w) - 1;
      a = longint'(m) & mask;
      b = longint'(q) & mask;
      if (s && a >= (one << (w - 1))) a = a - (one << w);
      if (s && b >= (one << (w - 1))) b = b - (one << w);
      return 32'((a * b) & ((one << (2 * w)) - 1));
   endfunction

   // one cycle of WIDTH=8 stimulus; the model decides what the coming edge does
   task automatic drv(input bit s, input bit a, input bit smv, input logic [7:0] mv, input logic [7:0] qv);
      int e;
      e = cyc + 1;
      start = s; abort = a; sm = smv; mc = mv; mp = qv;
      if (s && !a && e >= free_at) begin
         sb.push_back('{ref_prod(W, smv, {8'h00, mv}, {8'h00, qv}), e + W + 1});
         pacc = acc; pbu = bu;
         acc = e; bu = e + W + 1; free_at = e + W + 2;
         run_lo = e + 1; run_hi = e + W + 1;
      end else if (a && e >= run_lo && e <= run_hi) begin
         void'(sb.pop_back());
         bu = e - 1; free_at = e + 1; run_hi = -1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 1'b0, 1'($urandom % 2), 8'($urandom), 8'($urandom));
   endtask

   task automatic rnd(input int n, input bit hold_start);
      repeat (n) drv(hold_start ? 1'b1 : 1'($urandom % 2), hold_start ? 1'b0 : 1'($urandom % 16 == 0),
                     1'($urandom % 2), 8'($urandom), 8'($urandom));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL done_spurious: cycle %0d got done=1 expected done=0", cyc);
            end else begin
               mx = sb.pop_front();
               chk("product", 32'(prod), mx.p);
               chk("done_cycle", 32'(cyc), 32'(mx.c));
               last_prod = mx.p;
            end
         end else if (sb.size() > 0 && sb[0].c <= cyc) begin
            mx = sb.pop_front();
            n_vec++; n_err++;
            $display("FAIL done_missing: cycle %0d got done=0 expected done=1", cyc);
            last_prod = mx.p;
         end
         chk("busy", 32'(busy), 32'((cyc >= acc && cyc <= bu) || (cyc >= pacc && cyc <= pbu)));
         chk("product_hold", 32'(prod), last_prod);
      end
   end

   always @(negedge clk) begin
      if (rst2_n && done4) begin
         chk("w4_busy", 32'(busy4), 32'd1);
         if (exp4.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL w4_done_spurious: cycle %0d got done=1 expected done=0", cyc);
         end else chk("w4_product", 32'(prod4), exp4.pop_front());
      end
      if (rst2_n && done16) begin
         chk("w16_busy", 32'(busy16), 32'd1);
         if (exp16.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL w16_done_spurious: cycle %0d got done=1 expected done=0", cyc);
         end else chk("w16_product", prod16, exp16.pop_front());
      end
   end

   task automatic main_seq();
      drv(1, 0, 1, 8'h80, 8'h80); idle(W + 3);
      drv(1, 0, 1, 8'hFD, 8'h05); idle(W + 1);
      drv(1, 0, 1, 8'h07, 8'hFF); idle(W + 3);
      drv(1, 0, 0, 8'hFF, 8'hFF); idle(W + 3);
      drv(1, 0, 0, 8'hC8, 8'h03); idle(W + 3);
      rnd(5 * (W + 2), 1'b1); idle(W + 3);
      // second start mid-RUN must be ignored
      drv(1, 0, 1, 8'h11, 8'h22); idle(2); drv(1, 0, 0, 8'hAA, 8'hBB); idle(W + 2);
      // abort on the 4th RUN cycle
      drv(1, 0, 1, 8'h33, 8'h44); idle(3); drv(0, 1, 0, 8'h00, 8'h00); idle(W + 3);
      rnd(2500, 1'b0); idle(W + 3);
      // reset in the middle of RUN
      drv(1, 0, 1, 8'h5A, 8'hA5); idle(4);
      #2 rst_n = 1'b0;
      sb.delete();
      acc = 1 << 30; bu = -1; pacc = 1 << 30; pbu = -1;
      free_at = 0; run_lo = 0; run_hi = -1; last_prod = '0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_product", 32'(prod), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      drv(1, 0, 1, 8'h80, 8'h7F); idle(W + 3);
   endtask

   task automatic run4();
      for (int s = 0; s < 2; s++)
         for (int m = 0; m < 16; m++)
            for (int q = 0; q < 16; q++) begin
               s4 = 1'b1; sm4 = s[0]; m4 = 4'(m); q4v = 4'(q);
               exp4.push_back(ref_prod(W4, s[0], 16'(m), 16'(q)));
               @(negedge clk);
               s4 = 1'b0; sm4 = ~sm4; m4 = 4'($urandom); q4v = 4'($urandom);
               repeat (W4 + 1) @(negedge clk);
            end
   endtask

   task automatic run16();
      logic [15:0] a, b;
      bit          s;
      repeat (3000) begin
         a = 16'($urandom); b = 16'($urandom); s = 1'($urandom % 2);
         if ($urandom % 8 == 0) a = s ? 16'h8000 : 16'hFFFF;
         if ($urandom % 8 == 0) b = s ? 16'h8000 : 16'hFFFF;
         s16 = 1'b1; sm16 = s; m16 = a; q16v = b;
         exp16.push_back(ref_prod(W16, s, a, b));
         @(negedge clk);
         s16 = 1'b0; m16 = 16'($urandom); q16v = 16'($urandom);
         repeat (W16 + 1) @(negedge clk);
      end
   endtask

   initial begin
      start = 0; abort = 0; sm = 0; mc = '0; mp = '0;
      s4 = 0; ab4 = 0; sm4 = 0; m4 = '0; q4v = '0;
      s16 = 0; ab16 = 0; sm16 = 0; m16 = '0; q16v = '0;
      #1 rst_n = 1'b0; rst2_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_product", 32'(prod), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;
      fork
         main_seq();
         run4();
         run16();
      join
      repeat (W16 + 4) @(negedge clk);
      chk("w8_pending", 32'(sb.size()), 32'd0);
      chk("w4_pending", 32'(exp4.size()), 32'd0);
      chk("w16_pending", 32'(exp16.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
